// File: rtl/dma_fifo.sv
// DMA word FIFO: owns pointers/occupancy for an external async-read RAM (MEMIF F0 side).
// Define DMA_FIFO_ERR_FLAGS_EN to add sticky ovf/unf outputs and occupancy assertions.
module dma_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pull,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [AW:0]      depth_left,
  output logic             full,
  output logic             empty,
  input  logic             fp_pulse,
  output logic             mem_we,
  output logic [AW-1:0]    mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [AW-1:0]    mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef DMA_FIFO_ERR_FLAGS_EN
  ,
  output logic             ovf,
  output logic             unf
`endif
);

  localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CONE  = (AW+1)'(1);
  localparam logic [AW-1:0] L_PONE  = AW'(1);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pull;

  // Flags come straight from the registered count so they never glitch on push/pull.
  assign full       = (r_count == L_DEPTH);
  assign empty      = (r_count == '0);
  assign depth_left = L_DEPTH - r_count;

  assign w_push = push & ~full;
  assign w_pull = pull & ~empty;

  assign mem_we    = w_push & ~fp_pulse;
  assign mem_waddr = r_wr_ptr;
  assign mem_wdata = data_in;
  assign mem_raddr = r_rd_ptr;
  assign data_out  = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (fp_pulse) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PONE;
      if (w_pull) r_rd_ptr <= r_rd_ptr + L_PONE;
      if (w_push && !w_pull)      r_count <= r_count + L_CONE;
      else if (w_pull && !w_push) r_count <= r_count - L_CONE;
    end
  end

`ifdef DMA_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (fp_pulse) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push && full)  ovf <= 1'b1;
      if (pull && empty) unf <= 1'b1;
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst) r_count <= L_DEPTH);
  a_flags_excl: assert property (@(posedge clk) disable iff (!rst) !(full && empty));
`endif

endmodule

// File: tb/tb_dma_fifo.sv
// Randomized bench for dma_fifo against a queue-based reference model with an async-read RAM.
module tb_dma_fifo;
  logic        clk = 1'b0, rst = 1'b0, push = 1'b0, pull = 1'b0, fp_pulse = 1'b0;
  logic [31:0] data_in = '0, data_out, mem_wdata, mem_rdata;
  logic [5:0]  depth_left;
  logic [4:0]  mem_waddr, mem_raddr;
  logic        full, empty, mem_we;
`ifdef DMA_FIFO_ERR_FLAGS_EN
  logic        ovf, unf;
`endif

  dma_fifo dut (
    .clk(clk), .rst(rst), .push(push), .pull(pull), .data_in(data_in),
    .data_out(data_out), .depth_left(depth_left), .full(full), .empty(empty),
    .fp_pulse(fp_pulse), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
`ifdef DMA_FIFO_ERR_FLAGS_EN
    , .ovf(ovf), .unf(unf)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] ram [32];
  always @(posedge clk) if (mem_we) ram[mem_waddr] <= mem_wdata;
  assign mem_rdata = ram[mem_raddr];

  int n_tests = 0, n_fail = 0;
  logic [31:0] q [$];
  int wp = 0, rp = 0;
  bit ovf_m = 1'b0, unf_m = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete(); wp = 0; rp = 0; ovf_m = 1'b0; unf_m = 1'b0;
  endtask

  task automatic check_state();
    chk("depth_left", 32'(depth_left), 32'(32 - q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 32));
    chk("mem_raddr", 32'(mem_raddr), 32'(rp));
    if (q.size() > 0) chk("data_out", data_out, q[0]);
`ifdef DMA_FIFO_ERR_FLAGS_EN
    chk("ovf", 32'(ovf), 32'(ovf_m));
    chk("unf", 32'(unf), 32'(unf_m));
`endif
  endtask

  task automatic cyc(bit p, bit l, logic [31:0] d, bit f);
    bit ap, al;
    @(negedge clk);
    push = p; pull = l; data_in = d; fp_pulse = f;
    ap = p && (q.size() < 32);
    al = l && (q.size() > 0);
    #1;
    chk("mem_we", 32'(mem_we), 32'(ap && !f));
    if (ap && !f) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(wp));
      chk("mem_wdata", mem_wdata, d);
    end
    @(posedge clk);
    if (f) model_clear();
    else begin
      if (p && !ap) ovf_m = 1'b1;
      if (l && !al) unf_m = 1'b1;
      if (al) begin void'(q.pop_front()); rp = (rp + 1) % 32; end
      if (ap) begin q.push_back(d); wp = (wp + 1) % 32; end
    end
    #1;
    check_state();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    check_state();
    @(negedge clk) rst = 1'b1;
    cyc(0, 0, 32'h0, 0);

    // Fill, overflow attempt, drain, underflow attempt.
    for (int i = 0; i < 32; i++) cyc(1, 0, 32'(i), 0);
    cyc(1, 0, 32'hDEADBEEF, 0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 32'h0, 0);
    cyc(0, 1, 32'h0, 0);

    // Pointer wrap across 31->0.
    for (int i = 0; i < 20; i++) cyc(1, 0, $urandom, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 32'h0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, $urandom, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 32'h0, 0);

    // Concurrent push/pull with 5 stored, then at full.
    for (int i = 0; i < 10; i++) cyc(1, 1, $urandom, 0);
    for (int i = 0; i < 27; i++) cyc(1, 0, $urandom, 0);
    cyc(1, 1, $urandom, 0);

    // Flush with 12 stored while pushing.
    for (int i = 0; i < 19; i++) cyc(0, 1, 32'h0, 0);
    cyc(1, 0, 32'hA5A5A5A5, 1);
    cyc(1, 0, $urandom, 0);

    // Random traffic with occasional frame pulses.
    for (int i = 0; i < 600; i++) begin
      bit p, l;
      if (i % 200 < 80) begin p = ($urandom_range(0, 3) != 0); l = ($urandom_range(0, 3) == 0); end
      else if (i % 200 < 140) begin p = ($urandom_range(0, 3) == 0); l = ($urandom_range(0, 3) != 0); end
      else begin p = $urandom_range(0, 1) != 0; l = $urandom_range(0, 1) != 0; end
      cyc(p, l, $urandom, $urandom_range(0, 99) == 0);
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 10; i++) cyc(1, 0, $urandom, 0);
    @(negedge clk);
    push = 1'b1; data_in = 32'h12345678;
    #2 rst = 1'b0;
    #1;
    model_clear();
    chk("async_mem_we", 32'(mem_we), 32'd1);
    check_state();
    push = 1'b0;
    #1 chk("async_mem_we_idle", 32'(mem_we), 32'd0);
    @(negedge clk) rst = 1'b1;
    cyc(1, 0, 32'hCAFEF00D, 0);
    cyc(0, 1, 32'h0, 0);
    cyc(0, 0, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
